// File: rtl/rr_arb_4.sv
// rr_arb_4: four-input round-robin arbiter feeding a one-entry output register.
// A requester is granted only when the output stage can load: it is empty, or
// its item drains on the same edge. The search starts one past the last winner
// (ptr) and wraps 3->0. After reset ptr is 3, so requester 0 has first priority.
//
// Handshake: requester k hands over i_data<k> on an edge where o_grant[k]=1.
// The consumer takes o_data on an edge where o_valid=1 and i_ready=1. o_data
// and o_valid hold while o_valid=1 and i_ready=0.
//
// Optional feature: define RR_ARB_4_CNT_EN to add o_grant_cnt. This is a
// 16-bit saturating count of the edges on which a grant was issued.
module rr_arb_4 #(
    parameter int N_WIDTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [3:0]         i_valid,
    input  logic [N_WIDTH-1:0] i_data0,
    input  logic [N_WIDTH-1:0] i_data1,
    input  logic [N_WIDTH-1:0] i_data2,
    input  logic [N_WIDTH-1:0] i_data3,
    output logic [3:0]         o_grant,
    output logic [1:0]         o_sel,
    output logic               o_valid,
    output logic [N_WIDTH-1:0] o_data,
    input  logic               i_ready
`ifdef RR_ARB_4_CNT_EN
    ,
    output logic [15:0]        o_grant_cnt
`endif
);

    // The output buffer state is exactly what o_valid reports.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         sel_q;
    logic [N_WIDTH-1:0] data_q, data_d;
    logic               can_load;
    logic               grant_any;
    logic [1:0]         grant_idx;
    logic [1:0]         cand;
    logic [N_WIDTH-1:0] mux_data;

    assign can_load = (state_q == EMPTY) || i_ready;

    // Rotating priority search from ptr+1. The search sees only control
    // signals, so no i_data path reaches the grant.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        if (i_rst_n && can_load) begin
            for (int k = 1; k <= 4; k++) begin
                cand = ptr_q + 2'(k);
                if (!grant_any && i_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        o_grant = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
    end

    // Select follows the current winner and holds the last winner when idle.
    assign o_sel = grant_any ? grant_idx : sel_q;

    // Downstream 4:1 payload mux, driven by the select.
    always_comb begin
        case (o_sel)
            2'd0:    mux_data = i_data0;
            2'd1:    mux_data = i_data1;
            2'd2:    mux_data = i_data2;
            default: mux_data = i_data3;
        endcase
    end

    // Next-state logic. A drain and a load on the same edge keep the buffer
    // FULL, so there is no bubble between items.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (grant_any) state_d = FULL;
            FULL:    if (grant_any) state_d = FULL;
                     else if (i_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Buffer state register; reset drops any item being held.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= EMPTY;
        else          state_q <= state_d;
    end

    // Output decode of the buffer state.
    always_comb begin
        o_valid = (state_q == FULL);
    end

    // Payload and pointer change only when a grant is issued.
    always_comb begin
        data_d = data_q;
        ptr_d  = ptr_q;
        if (grant_any) begin
            data_d = mux_data;
            ptr_d  = grant_idx;
        end
    end

    // Payload, pointer and held select. After reset requester 0 has top priority.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data_q <= '0;
            ptr_q  <= 2'd3;
            sel_q  <= 2'd0;
        end else begin
            data_q <= data_d;
            ptr_q  <= ptr_d;
            sel_q  <= o_sel;
        end
    end

    assign o_data = data_q;

`ifdef RR_ARB_4_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Grant-edge counter that saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (grant_any && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    // Counter register, cleared by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) cnt_q <= 16'd0;
        else          cnt_q <= cnt_d;
    end

    assign o_grant_cnt = cnt_q;
`else
    // Without the counter option, this build has no grant counter.
`endif

endmodule

// File: tb/tb_rr_arb_4.sv
// tb_rr_arb_4: directed bench for rr_arb_4.
// The driver checks o_grant and o_sel every cycle. For each grant it pushes
// the expected payload into exp_q. The monitor pops and compares o_data each
// time the DUT hands an item to the consumer (o_valid && i_ready).
module tb_rr_arb_4;

    localparam int W = 4;

    logic         i_clk;
    logic         i_rst_n;
    logic [3:0]   i_valid;
    logic [W-1:0] i_data0, i_data1, i_data2, i_data3;
    logic [3:0]   o_grant;
    logic [1:0]   o_sel;
    logic         o_valid;
    logic [W-1:0] o_data;
    logic         i_ready;
`ifdef RR_ARB_4_CNT_EN
    logic [15:0]  o_grant_cnt;
`endif

    logic [W-1:0] exp_q[$];
    logic [W-1:0] req_data [4];
    int           chk_cnt  = 0;
    int           pass_cnt = 0;
    bit           mon_en   = 1'b1;

    rr_arb_4 #(.N_WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .i_data0 (i_data0),
        .i_data1 (i_data1),
        .i_data2 (i_data2),
        .i_data3 (i_data3),
        .o_grant (o_grant),
        .o_sel   (o_sel),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready)
`ifdef RR_ARB_4_CNT_EN
        ,
        .o_grant_cnt (o_grant_cnt)
`endif
    );

    // Clock and watchdog
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [W-1:0] d3);
        req_data[0] = d0; req_data[1] = d1; req_data[2] = d2; req_data[3] = d3;
        i_data0 = d0; i_data1 = d1; i_data2 = d2; i_data3 = d3;
    endtask

    // One cycle: drive the inputs, check the grant at the negedge, predict
    // the payload, and return 1 time unit after the next posedge.
    task automatic step(input logic [3:0] v, input logic r,
                        input logic [3:0] eg, input logic [1:0] es);
        i_valid = v;
        i_ready = r;
        @(negedge i_clk);
        chk("grant", 32'(o_grant), 32'(eg));
        chk("sel", 32'(o_sel), 32'(es));
        if (eg != 4'b0000) exp_q.push_back(req_data[es]);
        @(posedge i_clk);
        #1;
    endtask

    // Two reset cycles, then check the reset values and drop predictions.
    task automatic do_reset();
        i_rst_n = 1'b0;
        i_valid = 4'b1111;
        i_ready = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_grant", 32'(o_grant), 32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_data", 32'(o_data), 32'h0);
        chk("rst_sel", 32'(o_sel), 32'h0);
        @(posedge i_clk);
        #1;
        exp_q.delete();
        i_rst_n = 1'b1;
        i_valid = 4'b0000;
    endtask

    // Scoreboard monitor: compare each item the consumer accepts.
    always @(negedge i_clk) begin
        if (mon_en && i_rst_n === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_item", 32'(o_data), 32'hFFFF_FFFF);
            end else begin
                chk("data", 32'(o_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        i_rst_n = 1'b0;
        i_valid = 4'b0000;
        i_ready = 1'b0;
        set_data(4'h0, 4'h1, 4'h2, 4'h3);
        @(posedge i_clk);
        #1;

        // Full rotation after reset, starting at requester 0
        do_reset();
        step(4'b1111, 1'b1, 4'b0001, 2'd0);
        step(4'b1111, 1'b1, 4'b0010, 2'd1);
        step(4'b1111, 1'b1, 4'b0100, 2'd2);
        step(4'b1111, 1'b1, 4'b1000, 2'd3);
        step(4'b1111, 1'b1, 4'b0001, 2'd0);
        step(4'b0000, 1'b1, 4'b0000, 2'd0);

        // Backpressure holds o_data=2, then the grant resumes at requester 3
        do_reset();
        step(4'b1111, 1'b1, 4'b0001, 2'd0);
        step(4'b1111, 1'b1, 4'b0010, 2'd1);
        step(4'b1111, 1'b1, 4'b0100, 2'd2);
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b0, 4'b0000, 2'd2);
            chk("bp_valid", 32'(o_valid), 32'h1);
            chk("bp_data", 32'(o_data), 32'h2);
        end
        step(4'b1111, 1'b1, 4'b1000, 2'd3);
        step(4'b0000, 1'b1, 4'b0000, 2'd3);

        // Sparse requests alternate between requesters 1 and 3, then the buffer empties
        do_reset();
        set_data(4'h5, 4'h6, 4'h7, 4'h8);
        step(4'b1010, 1'b1, 4'b0010, 2'd1);
        step(4'b1010, 1'b1, 4'b1000, 2'd3);
        step(4'b1010, 1'b1, 4'b0010, 2'd1);
        step(4'b0000, 1'b1, 4'b0000, 2'd1);
        chk("drain_valid", 32'(o_valid), 32'h0);
        chk("drain_hold_data", 32'(o_data), 32'h6);

        // Reset in mid-operation discards the item held in the buffer
        do_reset();
        set_data(4'h0, 4'h1, 4'h2, 4'h3);
        step(4'b1000, 1'b1, 4'b1000, 2'd3);
        chk("full_data", 32'(o_data), 32'h3);
        i_rst_n = 1'b0;
        i_valid = 4'b1111;
        i_ready = 1'b0;
        @(negedge i_clk);
        chk("mid_rst_grant", 32'(o_grant), 32'h0);
        @(posedge i_clk);
        #1;
        exp_q.delete();
        chk("mid_rst_valid", 32'(o_valid), 32'h0);
        chk("mid_rst_data", 32'(o_data), 32'h0);
        i_rst_n = 1'b1;
        step(4'b1111, 1'b1, 4'b0001, 2'd0);
        step(4'b0000, 1'b1, 4'b0000, 2'd0);

`ifdef RR_ARB_4_CNT_EN
        // Counter: five grants, then saturation
        do_reset();
        chk("cnt_reset", 32'(o_grant_cnt), 32'h0);
        step(4'b0001, 1'b1, 4'b0001, 2'd0);
        step(4'b0001, 1'b1, 4'b0001, 2'd0);
        step(4'b0001, 1'b1, 4'b0001, 2'd0);
        step(4'b0001, 1'b1, 4'b0001, 2'd0);
        step(4'b0001, 1'b1, 4'b0001, 2'd0);
        step(4'b0000, 1'b1, 4'b0000, 2'd0);
        chk("cnt_5", 32'(o_grant_cnt), 32'd5);
        mon_en  = 1'b0;
        i_valid = 4'b1111;
        i_ready = 1'b1;
        repeat (70000) @(posedge i_clk);
        #1;
        chk("cnt_sat", 32'(o_grant_cnt), 32'hFFFF);
        do_reset();
        mon_en = 1'b1;
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/rr_arb_4.md
RR_ARB_4 -- requirements
Module: rr_arb_4

Interface
REQ-001 The module SHALL have parameter N_WIDTH, default 4, giving the data width of each input and of the output.
REQ-002 The module SHALL have port i_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port i_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The module SHALL have port i_valid, input, 4 bits: bit k set means requester k offers i_data<k>.
REQ-005 The module SHALL have ports i_data0, i_data1, i_data2 and i_data3, input, N_WIDTH bits each: requester payloads.
REQ-006 The module SHALL have port o_grant, input-accept, output, 4 bits: one-hot, combinational, and bit k set means i_data<k> is taken at this edge.
REQ-007 The module SHALL have port o_sel, output, 2 bits: binary index of the granted requester; it is the select for the downstream 4:1 multiplexer.
REQ-008 The module SHALL have port o_valid, output, 1 bit: o_data holds a valid item.
REQ-009 The module SHALL have port o_data, output, N_WIDTH bits: the registered payload.
REQ-010 The module SHALL have port i_ready, input, 1 bit: the consumer accepts o_data when o_valid and i_ready are both 1.

Function
REQ-011 The output stage SHALL be a one-entry buffer with states EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-012 The stage SHALL be able to load ("can_load") when o_valid=0 or i_ready=1.
REQ-013 When can_load=1 and i_valid≠0, exactly one o_grant bit SHALL be set: the first set i_valid bit searching upward from (ptr+1) mod 4, wrapping 3→0.
REQ-014 When can_load=0 or i_valid=0, o_grant SHALL be 4'b0000.
REQ-015 o_sel SHALL equal the index of the set o_grant bit; when o_grant=0, o_sel SHALL hold its previous value.
REQ-016 On an edge where o_grant≠0, o_data SHALL load i_data<o_sel>, o_valid SHALL become 1, and ptr SHALL become o_sel.
REQ-017 On an edge where o_valid=1, i_ready=1 and o_grant=0, o_valid SHALL become 0 and o_data SHALL hold its value.
REQ-018 On an edge where o_valid=1 and i_ready=0, o_data, o_valid and ptr SHALL remain unchanged.
REQ-019 Latency SHALL be 1 cycle from grant to o_valid.
REQ-020 Throughput SHALL be 1 item/cycle: simultaneous drain and load in one edge SHALL take the FULL→FULL transition with no bubble.
REQ-021 A requester that keeps i_valid asserted SHALL be granted within 4 load opportunities (starvation bound).
REQ-022 o_grant SHALL depend combinationally on i_valid, i_ready, o_valid and ptr only; the block SHALL contain no combinational path from i_data to any control output.

Reset
REQ-023 When i_rst_n=0 at an edge, the module SHALL set o_valid=0, o_data=0, o_sel=2'b00 and ptr=2'd3, so that requester 0 holds first priority.
REQ-024 While i_rst_n=0, o_grant SHALL be 4'b0000, and no payload SHALL be accepted.
REQ-025 Reset asserted while FULL SHALL discard the buffered item, and the item SHALL NOT be presented again after reset.

Configuration
REQ-026 When macro RR_ARB_4_CNT_EN is defined, the module SHALL add output o_grant_cnt, 16 bits, counting edges with o_grant≠0, saturating at 16'hFFFF; reset SHALL clear it to 0.
REQ-027 When RR_ARB_4_CNT_EN is undefined, port o_grant_cnt and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Reset scenario: release reset, i_valid=4'b1111, i_ready=1, data0..3=4'h0,4'h1,4'h2,4'h3 -> o_grant SHALL sequence 0001,0010,0100,1000,0001, and o_data SHALL be 0,1,2,3,0 one cycle later each.
REQ-029 Backpressure scenario: FULL with o_data=4'h2, i_ready=0 for 3 cycles with i_valid=4'b1111 -> o_grant SHALL be 0000 and o_data SHALL stay 4'h2; after i_ready=1, the next grant SHALL be 1000.
REQ-030 Sparse-request scenario: after reset, i_valid=4'b1010, i_ready=1 -> grants SHALL be 0010,1000,0010; with i_valid=0, o_valid SHALL drop to 0 one cycle after the last drain.
REQ-031 Mid-operation reset scenario: FULL with o_data=4'h3, i_rst_n=0 for 1 cycle -> o_valid=0 and o_data=0; the next grant with i_valid=4'b1111 SHALL be 0001.
REQ-032 Counter scenario (RR_ARB_4_CNT_EN defined): 5 grants -> o_grant_cnt SHALL be 5; after forcing 70000 grants, o_grant_cnt SHALL read 16'hFFFF.
